// File: rtl/sdr_xcorr_sequencer_pkg.sv
// Shared types for the SDR cross-correlation sequencer: sample/product widths
// and the multiplier-sharing FSM encoding.
package sdr_pkg;

    localparam int SAMPLE_W = 4;
    localparam int PROD_W   = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0]   prod_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4
    } state_t;

endpackage

// File: rtl/sdr_xcorr_sequencer_mul4s.sv
// Combinational 4x4 signed multiplier; the single product resource shared by
// all four partial products of a complex multiply.
module mul4s
    import sdr_pkg::*;
(
    input  sample_t a,
    input  sample_t b,
    output prod_t   p
);

    // Widen before multiplying so the full 8-bit signed product is kept.
    assign p = prod_t'(a) * prod_t'(b);

endmodule

// File: rtl/sdr_xcorr_sequencer.sv
// Accumulates sum(x0 * conj(x1)) over LEN sample pairs, reusing one signed
// multiplier across four cycles per pair.
//
// state | meaning
// IDLE  | waiting for a sample pair; in_ready = ena
// P0    | acc_re += i0*i1
// P1    | acc_re += q0*q1
// P2    | acc_im += q0*i1
// P3    | acc_im -= i0*q1; count window, publish result on last sample
module sdr_xcorr_sequencer
    import sdr_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [3:0]       i0,
    input  logic signed [3:0]       q0,
    input  logic signed [3:0]       i1,
    input  logic signed [3:0]       q1,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_re,
    output logic signed [ACC_W-1:0] out_im,
    output logic                    busy
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    state_t                   state;
    logic [CNT_W-1:0]         count;
    sample_t                  r_i0, r_q0, r_i1, r_q1;
    sample_t                  op_a, op_b;
    prod_t                    prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  acc_re, acc_im;
    logic signed [ACC_W-1:0]  acc_im_last;

    assign in_ready = !rst && ena && (state == IDLE);
    assign busy     = (state != IDLE) || (count != '0);

    always_comb begin
        op_a = r_i0;
        op_b = r_i1;
        case (state)
            P1:      begin op_a = r_q0; op_b = r_q1; end
            P2:      begin op_a = r_q0; op_b = r_i1; end
            P3:      begin op_a = r_i0; op_b = r_q1; end
            default: begin op_a = r_i0; op_b = r_i1; end
        endcase
    end

    mul4s u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    assign prod_x      = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // The final P3 result must include its own subtraction when published.
    assign acc_im_last = acc_im - prod_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            r_i0      <= '0;
            r_q0      <= '0;
            r_i1      <= '0;
            r_q1      <= '0;
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                state  <= IDLE;
                count  <= '0;
                acc_re <= '0;
                acc_im <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid && in_ready) begin
                            r_i0  <= i0;
                            r_q0  <= q0;
                            r_i1  <= i1;
                            r_q1  <= q1;
                            state <= P0;
                        end
                    end
                    P0: begin
                        acc_re <= acc_re + prod_x;
                        state  <= P1;
                    end
                    P1: begin
                        acc_re <= acc_re + prod_x;
                        state  <= P2;
                    end
                    P2: begin
                        acc_im <= acc_im + prod_x;
                        state  <= P3;
                    end
                    P3: begin
                        state <= IDLE;
                        if (count == CNT_W'(LEN-1)) begin
                            out_re    <= acc_re;
                            out_im    <= acc_im_last;
                            out_valid <= 1'b1;
                            acc_re    <= '0;
                            acc_im    <= '0;
                            count     <= '0;
                        end else begin
                            acc_im <= acc_im_last;
                            count  <= count + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sdr_xcorr_sequencer.md
# sdr_xcorr_sequencer

Sequencer for the SDR complex dot-product datapath. It accepts paired 4-bit I/Q samples from two channels, x0 = (i0, q0) and x1 = (i1, q1), and time-multiplexes one shared 4×4 signed multiplier over four cycles per sample pair. It accumulates the cross-correlation sum Σ x0·conj(x1) over a fixed window of LEN samples. It sits between the pad-level sample capture and the output formatting stage of the top-level template.

## Interface
- LEN, 8, samples per window; power of two, ≥ 2.
- ACC_W, 12, signed accumulator/output width; must be ≥ 9 + log2(LEN).

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  block enable; gates acceptance of new samples only
- clr  in  1  synchronous window abort; clears accumulators and count
- in_valid  in  1  sample pair available
- in_ready  out  1  block accepts a pair this cycle
- i0, q0  in  4 each  channel-0 sample, signed two's complement
- i1, q1  in  4 each  channel-1 sample, signed two's complement
- out_valid  out  1  one-cycle pulse: window result valid
- out_re  out  ACC_W  Σ(i0·i1 + q0·q1), signed
- out_im  out  ACC_W  Σ(q0·i1 − i0·q1), signed
- busy  out  1  FSM not in IDLE, or window count ≠ 0

## Operation
- FSM states: IDLE, P0, P1, P2, P3.
- In IDLE: in_ready = ena. On in_valid && in_ready:
  - the four samples are latched into operand registers;
  - the FSM moves to P0.
- Shared multiplier product per state (8-bit signed, sign-extended to ACC_W):
  - P0: acc_re += i0·i1
  - P1: acc_re += q0·q1
  - P2: acc_im += q0·i1
  - P3: acc_im −= i0·q1
- Transitions P0→P1→P2→P3 are unconditional. P3→IDLE.
- At the P3 edge, the window count increments.
- When the count reaches LEN−1 at the P3 edge:
  - out_re and out_im load the final sums, including the P3 update;
  - out_valid asserts for the next cycle only;
  - both accumulators and the count clear.
- out_re and out_im hold their value until the next window completes.
- Arithmetic wraps in two's complement; there is no saturation.
- ena low:
  - in_ready is 0;
  - an in-flight sample still completes P0..P3;
  - window state is preserved.
- in_valid outside IDLE is ignored; in_ready is 0 there.
- clr has priority over all operation except rst:
  - accumulators, count and FSM return to IDLE/0;
  - any in-flight product is discarded;
  - out_re, out_im and out_valid are unaffected, except that a coincident final P3 edge is suppressed.

## Timing
- Reset values: in_ready=0 during rst, then =ena. out_valid=0, out_re=0, out_im=0, busy=0, FSM=IDLE, count=0.
- Throughput: one sample pair per 5 cycles (the accept cycle plus P0..P3).
- Latency: if the final sample is accepted at edge k, out_valid is high in the cycle following edge k+4.
- Back-to-back windows:
  - the next window's first sample may be accepted in the same cycle out_valid is high;
  - no bubble beyond the normal 5-cycle cadence.
- rst mid-operation (any state): all outputs read their reset values in the cycle after the edge.

## Structure
- Package sdr_pkg:
  - SAMPLE_W = 4, PROD_W = 8;
  - state_t enum (IDLE, P0..P3);
  - signed sample typedef.
- Sub-module mul4s: combinational 4×4 signed multiplier, 8-bit result. The sequencer muxes its operands per state. The multiplier is a single instance, never duplicated.

## Test plan
- Reset with ena=1, in_valid=0 → all outputs 0; in_ready=1 in the first cycle after rst deasserts.
- LEN=8, constant x0 = x1 = (0 + 2j), in_valid held high → accepts at edges 0, 5, …, 35; out_valid only after edge 39; out_re=32, out_im=0.
- x0 = (3 + 1j), x1 = (1 − 2j) for 8 samples → out_re=8, out_im=56. Then a second window of (0+0j) samples with no gap → out_re=0, out_im=0.
- All inputs −8 for 8 samples → out_re=1024, out_im=0, no overflow at ACC_W=12.
- Three samples of (5+5j)·(5+5j), then clr pulsed in P1, then 8 samples of (1+0j)·(1+0j) → single out_valid with out_re=8, out_im=0.
- ena dropped during P2 → P3 completes; in_ready=0 until ena=1, and the window result is unchanged. rst asserted in P1 → all outputs 0 in the next cycle, and no out_valid.
